// File: rtl/iobus_intr_ctrl.sv
// IOBUS-mapped interrupt controller: synchronises and edge-detects source requests,
// latches them as pending, masks them, and drives INTR through a claim/complete handshake.
module iobus_intr_ctrl #(
   parameter int          N_SRC       = 4,
   parameter logic [31:0] BASE_AD     = 32'h11240000,
   parameter bit          ROUND_ROBIN = 1'b0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_SRC-1:0] IRQ_IN,
   input  logic [31:0]      IOBUS_ADDR,
   input  logic [31:0]      IOBUS_OUT,
   input  logic             IOBUS_WR,
   output logic [31:0]      IOBUS_IN,
   output logic             INTR
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

   localparam logic [3:0] LAST_INIT = 4'(N_SRC - 1);

   state_t           state, state_nxt;
   logic [N_SRC-1:0] sync1, sync2, prev, rise;
   logic [N_SRC-1:0] pending, pending_nxt, enable, enable_nxt;
   logic [N_SRC-1:0] req, w1c, clr, id_oh;
   logic [3:0]       id, id_nxt, last_id, last_id_nxt, winner;
   logic             sel_pend, sel_en, sel_claim, sel_cmpl, claim_ok, found;
   logic             unused_bits;
   int               start;

   // Bus semantics: there is no ready; a store is a one-cycle IOBUS_WR strobe that
   // commits at the CLK edge where the address matches, and reads are side-effect free.
   assign sel_pend  = (IOBUS_ADDR == BASE_AD);
   assign sel_en    = (IOBUS_ADDR == BASE_AD + 32'h4);
   assign sel_claim = (IOBUS_ADDR == BASE_AD + 32'h8);
   assign sel_cmpl  = (IOBUS_ADDR == BASE_AD + 32'hC);

   assign rise        = sync2 & ~prev;
   assign req         = pending & enable;
   assign claim_ok    = IOBUS_WR && sel_claim && (state == REQ) && (IOBUS_OUT[3:0] == id);
   assign INTR        = (state == REQ);
   assign unused_bits = &{1'b0, IOBUS_OUT};

   // Set wins over clear so an edge landing on its own claim/W1C is not lost.
   always_comb begin
      w1c   = '0;
      clr   = '0;
      id_oh = '0;
      if (IOBUS_WR && sel_pend) w1c = IOBUS_OUT[N_SRC-1:0];
      for (int i = 0; i < N_SRC; i++) begin
         id_oh[i] = (id == 4'(i));
         clr[i]   = claim_ok && (id == 4'(i));
      end
      pending_nxt = (pending & ~w1c & ~clr) | rise;
      enable_nxt  = (IOBUS_WR && sel_en) ? IOBUS_OUT[N_SRC-1:0] : enable;
   end

   always_comb begin
      winner = '0;
      found  = 1'b0;
      start  = (int'(last_id) + 1) % N_SRC;
      if (ROUND_ROBIN) begin
         for (int k = 0; k < N_SRC; k++) begin
            for (int i = 0; i < N_SRC; i++) begin
               if (!found && req[i] && (i == (start + k) % N_SRC)) begin
                  winner = 4'(i);
                  found  = 1'b1;
               end
            end
         end
      end else begin
         for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) winner = 4'(i);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      id_nxt      = id;
      last_id_nxt = last_id;
      case (state)
         IDLE: begin
            if (|req) begin
               id_nxt    = winner;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (claim_ok) begin
               state_nxt   = SERVICE;
               last_id_nxt = id;
            end else if (!(|(pending_nxt & enable_nxt & id_oh))) begin
               state_nxt = IDLE;
            end
         end
         SERVICE: begin
            if (IOBUS_WR && sel_cmpl) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      IOBUS_IN = '0;
      if (sel_pend)       IOBUS_IN[N_SRC-1:0] = pending;
      else if (sel_en)    IOBUS_IN[N_SRC-1:0] = enable;
      else if (sel_claim) IOBUS_IN = {(state == REQ), 27'b0, id};
      else if (sel_cmpl)  IOBUS_IN[1:0] = state;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1   <= '0;
         sync2   <= '0;
         prev    <= '0;
         pending <= '0;
         enable  <= '0;
         state   <= IDLE;
         id      <= '0;
         last_id <= LAST_INIT;
      end else begin
         sync1   <= IRQ_IN;
         sync2   <= sync1;
         prev    <= sync2;
         pending <= pending_nxt;
         enable  <= enable_nxt;
         state   <= state_nxt;
         id      <= id_nxt;
         last_id <= last_id_nxt;
      end
   end

endmodule

// File: tb/tb_iobus_intr_ctrl.sv
// Directed bench for iobus_intr_ctrl: a fixed-priority instance and a round-robin
// instance share clock, reset and IRQ lines but have separate IOBUS ports.
module tb_iobus_intr_ctrl;

   localparam logic [31:0] BASE   = 32'h11240000;
   localparam logic [31:0] A_PEND = BASE;
   localparam logic [31:0] A_EN   = BASE + 32'h4;
   localparam logic [31:0] A_CLM  = BASE + 32'h8;
   localparam logic [31:0] A_CMP  = BASE + 32'hC;

   logic        clk, rst;
   logic [3:0]  irq;
   logic [31:0] a0, w0, a1, w1, rd0, rd1;
   logic        wr0, wr1, intr0, intr1;
   logic [31:0] r0, r1;
   logic [3:0]  fx_exp [4];
   logic [3:0]  rr_exp [4];
   int          n_chk, n_bad;

   iobus_intr_ctrl #(.N_SRC(4), .BASE_AD(BASE), .ROUND_ROBIN(1'b0)) dut_fx (
      .CLK(clk), .RESET(rst), .IRQ_IN(irq), .IOBUS_ADDR(a0), .IOBUS_OUT(w0),
      .IOBUS_WR(wr0), .IOBUS_IN(rd0), .INTR(intr0));

   iobus_intr_ctrl #(.N_SRC(4), .BASE_AD(BASE), .ROUND_ROBIN(1'b1)) dut_rr (
      .CLK(clk), .RESET(rst), .IRQ_IN(irq), .IOBUS_ADDR(a1), .IOBUS_OUT(w1),
      .IOBUS_WR(wr1), .IOBUS_IN(rd1), .INTR(intr1));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      irq = '0;
      wr0 = 1'b0; wr1 = 1'b0;
      a0 = '0; a1 = '0; w0 = '0; w1 = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // driver tasks
   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] v0, input logic [31:0] v1);
      a0 = addr; a1 = addr; w0 = v0; w1 = v1;
      wr0 = 1'b1; wr1 = 1'b1;
      tick();
      wr0 = 1'b0; wr1 = 1'b0;
      a0 = '0; a1 = '0;
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] v0, output logic [31:0] v1);
      a0 = addr; a1 = addr;
      #1;
      v0 = rd0; v1 = rd1;
      a0 = '0; a1 = '0;
   endtask

   task automatic pulse(input logic [3:0] m);
      irq = m;
      tick();
      irq = '0;
   endtask

   // scoreboard check
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      fx_exp = '{4'd0, 4'd0, 4'd0, 4'd0};
      rr_exp = '{4'd0, 4'd1, 4'd0, 4'd1};

      // 1: reset state and basic flow
      do_reset();
      chk("rst_intr", {31'b0, intr0}, 32'h0);
      bus_rd(A_PEND, r0, r1); chk("rst_pend", r0, 32'h0);
      bus_rd(A_EN,   r0, r1); chk("rst_en",   r0, 32'h0);
      bus_rd(A_CLM,  r0, r1); chk("rst_claim", r0, 32'h0);
      bus_rd(A_CMP,  r0, r1); chk("rst_state", r0, 32'h0);
      bus_wr(A_EN, 32'h3, 32'h3);
      irq = 4'b0010;
      tick();                      // edge k samples the request
      irq = '0;
      chk("t1_intr_k", {31'b0, intr0}, 32'h0);
      tick();
      chk("t1_intr_k1", {31'b0, intr0}, 32'h0);
      tick();
      bus_rd(A_PEND, r0, r1); chk("t1_pend_k2", r0, 32'h2);
      chk("t1_intr_k2", {31'b0, intr0}, 32'h0);
      tick();
      chk("t1_intr_k3", {31'b0, intr0}, 32'h1);
      bus_rd(A_CLM, r0, r1); chk("t1_claim", r0, 32'h80000001);
      bus_wr(A_CLM, 32'h1, 32'h1);
      chk("t1_intr_svc", {31'b0, intr0}, 32'h0);
      bus_rd(A_PEND, r0, r1); chk("t1_pend_svc", r0, 32'h0);
      bus_rd(A_CMP,  r0, r1); chk("t1_state_svc", r0, 32'h2);
      bus_wr(A_CMP, 32'h0, 32'h0);
      bus_rd(A_CMP,  r0, r1); chk("t1_state_idle", r0, 32'h0);

      // 2: fixed priority
      do_reset();
      bus_wr(A_EN, 32'hF, 32'hF);
      pulse(4'b1100);
      repeat (3) tick();
      bus_rd(A_CLM, r0, r1); chk("t2_claim2", r0, 32'h80000002);
      bus_wr(A_CLM, 32'h2, 32'h2);
      bus_wr(A_CMP, 32'h0, 32'h0);
      tick();
      chk("t2_intr_re", {31'b0, intr0}, 32'h1);
      bus_rd(A_CLM,  r0, r1); chk("t2_claim3", r0, 32'h80000003);
      bus_rd(A_PEND, r0, r1); chk("t2_pend8", r0, 32'h8);
      bus_wr(A_CLM, 32'h3, 32'h3);
      bus_rd(A_PEND, r0, r1); chk("t2_pend0", r0, 32'h0);

      // 3: round-robin versus fixed priority, both sources pending at each arbitration
      do_reset();
      for (int r = 0; r < 4; r++) begin
         bus_wr(A_EN, 32'h0, 32'h0);
         bus_wr(A_CMP, 32'h0, 32'h0);
         pulse(4'b0011);
         repeat (3) tick();
         bus_wr(A_EN, 32'h3, 32'h3);
         chk($sformatf("t3_prewrite_%0d", r), {31'b0, intr0}, 32'h0);
         tick();
         bus_rd(A_CLM, r0, r1);
         chk($sformatf("t3_fx_id_%0d", r), r0, {28'h8000000, fx_exp[r]});
         chk($sformatf("t3_rr_id_%0d", r), r1, {28'h8000000, rr_exp[r]});
         bus_wr(A_CLM, {28'h0, fx_exp[r]}, {28'h0, rr_exp[r]});
         bus_rd(A_CMP, r0, r1);
         chk($sformatf("t3_fx_svc_%0d", r), r0, 32'h2);
         chk($sformatf("t3_rr_svc_%0d", r), r1, 32'h2);
      end

      // 4: mask withdraws the request
      do_reset();
      bus_wr(A_EN, 32'h1, 32'h1);
      pulse(4'b0001);
      repeat (3) tick();
      chk("t4_intr_req", {31'b0, intr0}, 32'h1);
      bus_rd(A_CLM, r0, r1); chk("t4_claim", r0, 32'h80000000);
      bus_wr(A_EN, 32'h0, 32'h0);
      chk("t4_intr_drop", {31'b0, intr0}, 32'h0);
      bus_rd(A_CMP,  r0, r1); chk("t4_state_idle", r0, 32'h0);
      bus_rd(A_PEND, r0, r1); chk("t4_pend_kept", r0, 32'h1);
      bus_wr(A_EN, 32'h1, 32'h1);
      tick();
      chk("t4_intr_again", {31'b0, intr0}, 32'h1);
      bus_rd(A_CLM, r0, r1); chk("t4_claim_again", r0, 32'h80000000);

      // 5: boundaries
      bus_wr(A_CLM, 32'h2, 32'h2);
      chk("t5_badclaim_intr", {31'b0, intr0}, 32'h1);
      bus_rd(A_CMP, r0, r1); chk("t5_badclaim_state", r0, 32'h1);
      bus_wr(A_CMP, 32'h0, 32'h0);
      bus_rd(A_CMP, r0, r1); chk("t5_cmpl_in_req", r0, 32'h1);
      bus_wr(A_CLM, 32'h10, 32'h10);
      bus_rd(A_CMP,  r0, r1); chk("t5_nibble_claim", r0, 32'h2);
      bus_rd(A_PEND, r0, r1); chk("t5_nibble_pend", r0, 32'h0);
      bus_wr(A_CMP, 32'h0, 32'h0);
      pulse(4'b0001);
      repeat (3) tick();
      chk("t5_req_before_race", {31'b0, intr0}, 32'h1);
      irq = 4'b0001;
      tick();
      tick();
      bus_wr(A_CLM, 32'h0, 32'h0);   // lands on the edge that sets pending[0]
      bus_rd(A_PEND, r0, r1); chk("t5_race_pend", r0, 32'h1);
      bus_rd(A_CMP,  r0, r1); chk("t5_race_state", r0, 32'h2);
      chk("t5_race_intr", {31'b0, intr0}, 32'h0);
      bus_wr(A_CMP, 32'h0, 32'h0);
      tick();
      chk("t5_race_rereq", {31'b0, intr0}, 32'h1);
      bus_rd(A_CLM, r0, r1); chk("t5_race_claim", r0, 32'h80000000);
      irq = '0;

      do_reset();
      irq = 4'b0001;
      repeat (10) tick();
      bus_rd(A_PEND, r0, r1); chk("t5_held_pend1", r0, 32'h1);
      bus_wr(A_PEND, 32'h1, 32'h1);
      repeat (90) tick();
      bus_rd(A_PEND, r0, r1); chk("t5_held_pend0", r0, 32'h0);
      irq = '0;

      // 6: asynchronous reset mid-service and out-of-window reads
      do_reset();
      bus_wr(A_EN, 32'hF, 32'hF);
      pulse(4'b0010);
      repeat (3) tick();
      bus_wr(A_CLM, 32'h1, 32'h1);
      pulse(4'b0110);
      repeat (3) tick();
      bus_rd(A_PEND, r0, r1); chk("t6_pend6", r0, 32'h6);
      bus_rd(A_CMP,  r0, r1); chk("t6_state_svc", r0, 32'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_intr", {31'b0, intr0}, 32'h0);
      bus_rd(A_PEND, r0, r1); chk("t6_rst_pend", r0, 32'h0);
      bus_rd(A_EN,   r0, r1); chk("t6_rst_en", r0, 32'h0);
      bus_rd(A_CMP,  r0, r1); chk("t6_rst_state", r0, 32'h0);
      tick();
      rst = 1'b0;
      bus_wr(A_EN, 32'hF, 32'hF);
      bus_rd(32'h11000000, r0, r1); chk("t6_outside", r0, 32'h0);
      bus_rd(BASE + 32'h10, r0, r1); chk("t6_past_window", r0, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
